// File: rtl/acam_fifo_readout_ctrl.sv
// ACAM TDC FIFO readout sequencer.
// Round-robin reads of the two ACAM readout FIFOs with programmable rd_n timing.
// Each 28-bit word is tagged with its source FIFO and offered on a single-entry
// valid/ready output register.
module acam_fifo_readout_ctrl #(
   parameter int unsigned g_rd_low_cycles   = 4,  // 1..15
   parameter int unsigned g_recovery_cycles = 4,  // >= 3, <= 256
   parameter int unsigned g_sync_stages     = 2   // >= 1
) (
   input  logic        clk_sys_i,
   input  logic        rst_i,
   input  logic        enable_i,
   input  logic        acam_ef1_i,
   input  logic        acam_ef2_i,
   input  logic [27:0] acam_data_i,
   output logic [3:0]  acam_addr_o,
   output logic        acam_cs_n_o,
   output logic        acam_rd_n_o,
   output logic [27:0] data_o,
   output logic        fifo_id_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        busy_o,
   output logic [31:0] rd_count_o
);

   localparam int unsigned CntW = 8;
   localparam logic [3:0] AddrFifo1 = 4'd8;
   localparam logic [3:0] AddrFifo2 = 4'd9;

   typedef enum logic [1:0] {StIdle, StSetup, StRdLow, StRecover} state_e;

   state_e                   state_q;
   logic [CntW-1:0]          cnt_q;
   logic [g_sync_stages-1:0] ef1_sync_q;
   logic [g_sync_stages-1:0] ef2_sync_q;
   logic [3:0]               addr_q;
   logic                     cs_n_q;
   logic                     rd_n_q;
   logic [27:0]              data_q;
   logic                     fifo_id_q;
   logic                     valid_q;
   logic                     busy_q;
   logic [31:0]              rd_count_q;
   logic                     last_fifo_q;  // FIFO served most recently (1 = FIFO2)

   logic ef1_s;
   logic ef2_s;
   logic sel_fifo;
   logic start_rd;

   // Synchronize the asynchronous empty flags; reset to "empty"
   always_ff @(posedge clk_sys_i or posedge rst_i) begin
      if (rst_i) begin
         ef1_sync_q <= '1;
         ef2_sync_q <= '1;
      end else begin
         ef1_sync_q[0] <= acam_ef1_i;
         ef2_sync_q[0] <= acam_ef2_i;
         for (int i = 1; i < int'(g_sync_stages); i++) begin
            ef1_sync_q[i] <= ef1_sync_q[i-1];
            ef2_sync_q[i] <= ef2_sync_q[i-1];
         end
      end
   end

   assign ef1_s = ef1_sync_q[g_sync_stages-1];
   assign ef2_s = ef2_sync_q[g_sync_stages-1];

   // Round-robin selection and read-start qualification
   always_comb begin
      sel_fifo = 1'b0;
      if (!ef1_s && !ef2_s) begin
         sel_fifo = ~last_fifo_q;
      end else begin
         sel_fifo = ef1_s;  // only FIFO2 (or nothing) has data
      end
      start_rd = enable_i && (!valid_q || ready_i) && (!ef1_s || !ef2_s);
   end

   // Read sequencer with registered strobes and output register
   always_ff @(posedge clk_sys_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         addr_q      <= AddrFifo1;
         cs_n_q      <= 1'b1;
         rd_n_q      <= 1'b1;
         data_q      <= '0;
         fifo_id_q   <= 1'b0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         rd_count_q  <= '0;
         last_fifo_q <= 1'b1;  // makes FIFO1 preferred first
      end else begin
         // Consumer handshake; a capture on the same edge overrides this below
         if (valid_q && ready_i) begin
            valid_q <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               if (start_rd) begin
                  state_q     <= StSetup;
                  addr_q      <= sel_fifo ? AddrFifo2 : AddrFifo1;
                  cs_n_q      <= 1'b0;
                  last_fifo_q <= sel_fifo;
                  busy_q      <= 1'b1;
               end
            end
            StSetup: begin
               state_q <= StRdLow;
               rd_n_q  <= 1'b0;
               cnt_q   <= CntW'(g_rd_low_cycles - 1);
            end
            StRdLow: begin
               if (cnt_q == '0) begin
                  data_q     <= acam_data_i;
                  fifo_id_q  <= last_fifo_q;
                  valid_q    <= 1'b1;
                  rd_count_q <= rd_count_q + 32'd1;
                  rd_n_q     <= 1'b1;
                  cs_n_q     <= 1'b1;
                  state_q    <= StRecover;
                  cnt_q      <= CntW'(g_recovery_cycles - 1);
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StRecover: begin
               // Flags are ignored here while the ACAM and synchronizers settle
               if (cnt_q == '0) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign acam_addr_o = addr_q;
   assign acam_cs_n_o = cs_n_q;
   assign acam_rd_n_o = rd_n_q;
   assign data_o      = data_q;
   assign fifo_id_o   = fifo_id_q;
   assign valid_o     = valid_q;
   assign busy_o      = busy_q;
   assign rd_count_o  = rd_count_q;

endmodule

// File: tb/tb_acam_fifo_readout_ctrl.sv
// Bench for acam_fifo_readout_ctrl: behavioural ACAM FIFO model, protocol monitor
// and a spec-level prediction of delivered words.
module tb_acam_fifo_readout_ctrl;

   logic        clk_sys_i   = 1'b0;
   logic        rst_i       = 1'b1;
   logic        enable_i    = 1'b0;
   logic        ready_i     = 1'b0;
   logic        acam_ef1_i  = 1'b1;
   logic        acam_ef2_i  = 1'b1;
   logic [27:0] acam_data_i = 28'h0;
   logic [3:0]  acam_addr_o;
   logic        acam_cs_n_o;
   logic        acam_rd_n_o;
   logic [27:0] data_o;
   logic        fifo_id_o;
   logic        valid_o;
   logic        busy_o;
   logic [31:0] rd_count_o;

   acam_fifo_readout_ctrl dut (
      .clk_sys_i   (clk_sys_i),
      .rst_i       (rst_i),
      .enable_i    (enable_i),
      .acam_ef1_i  (acam_ef1_i),
      .acam_ef2_i  (acam_ef2_i),
      .acam_data_i (acam_data_i),
      .acam_addr_o (acam_addr_o),
      .acam_cs_n_o (acam_cs_n_o),
      .acam_rd_n_o (acam_rd_n_o),
      .data_o      (data_o),
      .fifo_id_o   (fifo_id_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .busy_o      (busy_o),
      .rd_count_o  (rd_count_o)
   );

   // 125 MHz system clock
   always #4 clk_sys_i = ~clk_sys_i;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   logic [31:0] exp_count = '0;
   logic        last_srv  = 1'b1;

   // ACAM FIFO contents, and the words still to be predicted
   logic [27:0] q1[$];
   logic [27:0] q2[$];
   logic [27:0] m1[$];
   logic [27:0] m2[$];
   logic [28:0] exp_q[$];
   logic [28:0] deliv_q[$];

   // Monitor records
   int          rd_len_q[$];
   int          rd_start_q[$];
   logic [3:0]  rd_addr_q[$];
   bit          in_rd = 1'b0;
   logic [3:0]  rd_addr;
   int          low_cnt;
   int          rd_start;
   int          strobe_viol = 0;
   int          addr_viol   = 0;
   int          hold_viol   = 0;
   logic        prev_cs_n   = 1'b1;
   logic [3:0]  prev_addr   = 4'd8;
   logic        prev_valid  = 1'b0;
   logic        prev_ready  = 1'b0;
   logic [27:0] prev_data   = '0;
   logic        prev_id     = 1'b0;
   logic [3:0]  pop_addr;

   always @(posedge clk_sys_i) cyc++;

   // ACAM bus model: flags and data follow the FIFO contents
   always #1 begin
      acam_ef1_i = (q1.size() == 0);
      acam_ef2_i = (q2.size() == 0);
      if (acam_addr_o == 4'd9) acam_data_i = (q2.size() > 0) ? q2[0] : 28'h0;
      else acam_data_i = (q1.size() > 0) ? q1[0] : 28'h0;
   end

   // A completed read pops the addressed FIFO 10 ns after rd_n rises
   always @(posedge acam_rd_n_o) begin
      if (rst_i !== 1'b1) begin
         pop_addr = acam_addr_o;
         #10;
         if (pop_addr == 4'd9) begin
            if (q2.size() > 0) void'(q2.pop_front());
         end else if (q1.size() > 0) begin
            void'(q1.pop_front());
         end
      end
   end

   // Protocol monitor: read strobes, address stability, handshake hold, deliveries
   always @(negedge clk_sys_i) begin
      if (rst_i) begin
         in_rd      = 1'b0;
         prev_valid = 1'b0;
         prev_cs_n  = 1'b1;
      end else begin
         if (!acam_rd_n_o) begin
            if (!in_rd) begin
               in_rd    = 1'b1;
               rd_addr  = acam_addr_o;
               low_cnt  = 0;
               rd_start = cyc;
            end
            low_cnt++;
         end else if (in_rd) begin
            in_rd = 1'b0;
            rd_len_q.push_back(low_cnt);
            rd_addr_q.push_back(rd_addr);
            rd_start_q.push_back(rd_start);
         end
         if (!acam_rd_n_o && acam_cs_n_o) strobe_viol++;
         if (!prev_cs_n && !acam_cs_n_o && acam_addr_o !== prev_addr) addr_viol++;
         if (prev_valid && !prev_ready &&
             (!valid_o || data_o !== prev_data || fifo_id_o !== prev_id)) hold_viol++;
         if (valid_o && ready_i) deliv_q.push_back({fifo_id_o, data_o});
         prev_cs_n  = acam_cs_n_o;
         prev_addr  = acam_addr_o;
         prev_valid = valid_o;
         prev_ready = ready_i;
         prev_data  = data_o;
         prev_id    = fifo_id_o;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_sys_i);
         #1;
      end
   endtask

   task automatic load(input bit id, input logic [27:0] w);
      if (id) begin
         q2.push_back(w);
         m2.push_back(w);
      end else begin
         q1.push_back(w);
         m1.push_back(w);
      end
   endtask

   // Expected service order: alternate when both hold data, else serve the non-empty one
   task automatic predict();
      while (m1.size() > 0 || m2.size() > 0) begin
         bit id;
         if (m1.size() > 0 && m2.size() > 0) id = ~last_srv;
         else id = (m1.size() == 0);
         if (id) exp_q.push_back({1'b1, m2.pop_front()});
         else exp_q.push_back({1'b0, m1.pop_front()});
         last_srv = id;
         exp_count = exp_count + 32'd1;
      end
   endtask

   task automatic wait_deliv(input int n, input int budget, input string tag);
      int k = 0;
      while (deliv_q.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      chk({tag, "_deliv_cnt"}, 32'(deliv_q.size()), 32'(n));
   endtask

   task automatic check_deliv(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         if (deliv_q.size() > 0 && exp_q.size() > 0) begin
            logic [28:0] got;
            logic [28:0] exp;
            got = deliv_q.pop_front();
            exp = exp_q.pop_front();
            chk($sformatf("%s_id%0d", tag, i), 32'(got[28]), 32'(exp[28]));
            chk($sformatf("%s_data%0d", tag, i), 32'(got[27:0]), 32'(exp[27:0]));
         end
      end
   endtask

   task automatic wait_rd_low(input string tag);
      int k = 0;
      while (acam_rd_n_o && k < 100) begin
         tick(1);
         k++;
      end
      chk(tag, 32'(acam_rd_n_o), 32'd0);
   endtask

   task automatic clear_mon();
      rd_len_q.delete();
      rd_addr_q.delete();
      rd_start_q.delete();
   endtask

   initial begin
      int k;
      int n1;
      int n2;

      // Reset state
      tick(3);
      chk("rst_addr", 32'(acam_addr_o), 32'd8);
      chk("rst_cs_n", 32'(acam_cs_n_o), 32'd1);
      chk("rst_rd_n", 32'(acam_rd_n_o), 32'd1);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_data", 32'(data_o), 32'd0);
      chk("rst_id", 32'(fifo_id_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_count", rd_count_o, 32'd0);
      rst_i = 1'b0;
      tick(2);

      // Single FIFO1 event
      ready_i  = 1'b1;
      enable_i = 1'b1;
      load(1'b0, 28'h0ABCDEF);
      predict();
      k = 0;
      while (!valid_o && k < 50) begin
         tick(1);
         k++;
      end
      chk("s1_valid", 32'(valid_o), 32'd1);
      chk("s1_data", 32'(data_o), 32'h0ABCDEF);
      chk("s1_id", 32'(fifo_id_o), 32'd0);
      chk("s1_count", rd_count_o, exp_count);
      tick(1);
      chk("s1_valid_pulse", 32'(valid_o), 32'd0);
      tick(40);
      chk("s1_reads", 32'(rd_len_q.size()), 32'd1);
      if (rd_len_q.size() > 0) begin
         chk("s1_rd_len", 32'(rd_len_q[0]), 32'd4);
         chk("s1_addr", 32'(rd_addr_q[0]), 32'd8);
      end
      chk("s1_busy", 32'(busy_o), 32'd0);
      wait_deliv(1, 10, "s1");
      check_deliv(1, "s1");
      clear_mon();

      // Both FIFOs non-empty, fresh arbitration pointer
      rst_i = 1'b1;
      tick(1);
      rst_i     = 1'b0;
      last_srv  = 1'b1;
      exp_count = '0;
      for (int i = 0; i < 3; i++) begin
         load(1'b0, 28'($urandom));
         load(1'b1, 28'($urandom));
      end
      predict();
      wait_deliv(6, 200, "s2");
      chk("s2_reads", 32'(rd_len_q.size()), 32'd6);
      for (int i = 0; i < rd_len_q.size() && i < exp_q.size(); i++) begin
         chk($sformatf("s2_len%0d", i), 32'(rd_len_q[i]), 32'd4);
         chk($sformatf("s2_addr%0d", i), 32'(rd_addr_q[i]), exp_q[i][28] ? 32'd9 : 32'd8);
         if (i > 0) chk($sformatf("s2_gap%0d", i), 32'(rd_start_q[i] - rd_start_q[i-1]), 32'd10);
      end
      check_deliv(6, "s2");
      chk("s2_count", rd_count_o, exp_count);
      tick(20);
      clear_mon();

      // Random load with random consumer backpressure
      n1 = $urandom_range(1, 5);
      n2 = $urandom_range(1, 5);
      for (int i = 0; i < n1; i++) load(1'b0, 28'($urandom));
      for (int i = 0; i < n2; i++) load(1'b1, 28'($urandom));
      predict();
      k = 0;
      while (deliv_q.size() < n1 + n2 && k < 800) begin
         ready_i = 1'($urandom % 2);
         tick(1);
         k++;
      end
      ready_i = 1'b1;
      chk("s3_deliv_cnt", 32'(deliv_q.size()), 32'(n1 + n2));
      check_deliv(n1 + n2, "s3");
      chk("s3_count", rd_count_o, exp_count);
      tick(20);
      clear_mon();

      // Sustained backpressure
      ready_i = 1'b0;
      for (int i = 0; i < 3; i++) load(1'b0, 28'($urandom));
      predict();
      tick(50);
      chk("s4_reads", 32'(rd_len_q.size()), 32'd1);
      chk("s4_valid", 32'(valid_o), 32'd1);
      chk("s4_data", 32'(data_o), 32'(exp_q[0][27:0]));
      chk("s4_rd_n", 32'(acam_rd_n_o), 32'd1);
      chk("s4_cs_n", 32'(acam_cs_n_o), 32'd1);
      ready_i = 1'b1;
      tick(1);
      chk("s4_setup_cs_n", 32'(acam_cs_n_o), 32'd0);
      chk("s4_setup_rd_n", 32'(acam_rd_n_o), 32'd1);
      chk("s4_setup_addr", 32'(acam_addr_o), 32'd8);
      chk("s4_valid_taken", 32'(valid_o), 32'd0);
      wait_deliv(3, 100, "s4");
      check_deliv(3, "s4");
      tick(20);
      clear_mon();

      // enable_i dropped during RD_LOW
      load(1'b0, 28'($urandom));
      load(1'b0, 28'($urandom));
      predict();
      wait_rd_low("s5_rd_low");
      tick(1);
      enable_i = 1'b0;
      chk("s5_still_low", 32'(acam_rd_n_o), 32'd0);
      wait_deliv(1, 50, "s5a");
      check_deliv(1, "s5a");
      tick(40);
      chk("s5_reads", 32'(rd_len_q.size()), 32'd1);
      chk("s5_busy", 32'(busy_o), 32'd0);
      enable_i = 1'b1;
      wait_deliv(1, 50, "s5b");
      check_deliv(1, "s5b");
      tick(20);
      clear_mon();

      // Reset pulse during RD_LOW
      load(1'b0, 28'($urandom));
      wait_rd_low("s6_rd_low");
      tick(1);
      #1 rst_i = 1'b1;
      #1;
      chk("s6_rd_n", 32'(acam_rd_n_o), 32'd1);
      chk("s6_cs_n", 32'(acam_cs_n_o), 32'd1);
      chk("s6_valid", 32'(valid_o), 32'd0);
      chk("s6_count", rd_count_o, 32'd0);
      tick(2);
      rst_i     = 1'b0;
      last_srv  = 1'b1;
      exp_count = '0;
      predict();
      wait_deliv(1, 60, "s6");
      check_deliv(1, "s6");
      chk("s6_count_after", rd_count_o, exp_count);
      tick(20);
      clear_mon();

      // Read counter wrap
      force dut.rd_count_q = 32'hFFFF_FFFF;
      tick(1);
      release dut.rd_count_q;
      chk("s7_preload", rd_count_o, 32'hFFFF_FFFF);
      exp_count = 32'hFFFF_FFFF;
      load(1'b1, 28'($urandom));
      predict();
      wait_deliv(1, 60, "s7");
      check_deliv(1, "s7");
      chk("s7_wrap", rd_count_o, exp_count);
      tick(20);

      // Protocol invariants over the whole run
      chk("strobe_viol", 32'(strobe_viol), 32'd0);
      chk("addr_viol", 32'(addr_viol), 32'd0);
      chk("hold_viol", 32'(hold_viol), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/acam_fifo_readout_ctrl.md
Name: acam_fifo_readout_ctrl

Overview:
- Read sequencer for the two ACAM TDC readout FIFOs on the TDC mezzanine.
- Watches the ACAM empty flags (ef1/ef2, active-low "data present"), arbitrates round-robin between the two FIFOs, and generates the address/cs_n/rd_n read strobes with programmable timing.
- Pushes each 28-bit timestamp word, tagged with its source FIFO, into a single-entry valid/ready output register.
- Sits between the mezzanine pins and the timestamp decoding logic in the system clock domain.

Parameters:
- g_rd_low_cycles, 4: number of clk_sys_i cycles rd_n is held low; legal range 1..15.
- g_recovery_cycles, 4: idle cycles after rd_n rises before the empty flags are re-evaluated; must be ≥3 to cover flag update plus synchronizer lag.
- g_sync_stages, 2: synchronizer depth on ef1/ef2.

Ports:
- clk_sys_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- enable_i  in  1  readout enable
- acam_ef1_i  in  1  FIFO1 empty flag; 0 = not empty (asynchronous)
- acam_ef2_i  in  1  FIFO2 empty flag; 0 = not empty (asynchronous)
- acam_data_i  in  28  ACAM data bus
- acam_addr_o  out  4  ACAM register address; 8 = FIFO1, 9 = FIFO2
- acam_cs_n_o  out  1  chip select, active low
- acam_rd_n_o  out  1  read strobe, active low
- data_o  out  28  captured timestamp word
- fifo_id_o  out  1  source FIFO of data_o; 0 = FIFO1, 1 = FIFO2
- valid_o  out  1  data_o/fifo_id_o valid
- ready_i  in  1  consumer accepts when valid_o and ready_i are both high
- busy_o  out  1  high in any state other than IDLE
- rd_count_o  out  32  total completed reads, wraps

Behaviour:
- Reset state (asynchronous on rst_i): acam_rd_n_o=1, acam_cs_n_o=1, acam_addr_o=8, valid_o=0, data_o=0, fifo_id_o=0, busy_o=0, rd_count_o=0, round-robin pointer=FIFO1 preferred, FSM=IDLE, synchronizers set to 1 (empty).
- Reset asserted mid-read releases rd_n/cs_n immediately (asynchronously), discards the partial read and clears valid_o.
- ef1/ef2 pass through g_sync_stages flops. Only the synchronized values are used.
- FSM states and transitions:
  - IDLE: start a read when enable_i=1, the output slot is free (valid_o=0, or valid_o=1 with ready_i=1 in the same cycle), and at least one synchronized ef is 0. Then go to SETUP.
  - SETUP, 1 cycle: acam_addr_o = 8 or 9 per the selected FIFO, cs_n=0, rd_n=1.
  - RD_LOW, g_rd_low_cycles cycles: cs_n=0, rd_n=0, address held.
  - On the clock edge ending the last RD_LOW cycle:
    - acam_data_i is captured into data_o and fifo_id_o is set.
    - valid_o goes to 1.
    - rd_count_o increments (wraps 0xFFFFFFFF→0).
    - rd_n and cs_n return to 1.
    - FSM moves to RECOVER.
  - RECOVER, g_recovery_cycles cycles: ef inputs are ignored. Then return to IDLE.
- Arbitration:
  - Only one FIFO non-empty: serve it.
  - Both non-empty: serve the FIFO not served last.
  - The pointer updates on entry to SETUP.
- Throughput: one word per (1 + g_rd_low_cycles + g_recovery_cycles + 1) cycles, i.e. 10 cycles at defaults.
- Latency, ef_sync=0 seen in IDLE at cycle N:
  - SETUP at N+1.
  - rd_n low from N+2 through N+1+g_rd_low_cycles.
  - valid_o=1 at N+2+g_rd_low_cycles.
- Output handshake:
  - valid_o stays high and data_o/fifo_id_o stay stable until a cycle with ready_i=1.
  - valid_o clears on that edge unless a new capture occurs on the same edge, in which case the new word replaces it and valid_o stays 1.
  - While valid_o=1 and ready_i=0, no new read starts. The ACAM FIFOs absorb backpressure.
- enable_i deassertion never aborts an in-progress read: the sequence completes through RECOVER, then the FSM holds in IDLE.
- rd_n is never low while cs_n is high. The address changes only while cs_n=1.

Test Plan:
- Single FIFO1 event: ef1 falls for one read and rises 10 ns after rd_n rises, acam_data_i=0x0ABCDEF. Required: addr=8; rd_n low exactly 4 cycles; data_o=0x0ABCDEF, fifo_id_o=0, valid_o for 1 cycle with ready_i=1; rd_count_o=1; no second read.
- Both flags held low with data toggling per read, ready_i=1, 6 reads. Required: fifo_id_o sequence 0,1,0,1,0,1; reads spaced 10 cycles apart.
- Backpressure: ef1 held low, ready_i=0 for 50 cycles. Required: exactly one read, valid_o held with stable data, rd_n stays high. After ready_i=1, the next SETUP starts in the same cycle.
- enable_i dropped two cycles into RD_LOW. Required: the read completes, the word is delivered, no further reads while ef1 stays low; reads resume when enable_i=1.
- rst_i pulsed during RD_LOW. Required: rd_n=1 and cs_n=1 immediately, valid_o=0, rd_count_o=0; reads restart after release if ef1 is still low.
- rd_count_o preloaded via force to 0xFFFFFFFF, one read. Required: rd_count_o=0.
